out_mem_drain: RTL and testbench
================================

# out_mem_drain

Streams a rectangle of finished rows out of the output memory array (post-ReLU results written by the output controller) onto a valid/ready beat interface toward the DMA/next-layer loader. Sits directly downstream of the output memory. Reads one full row (all SYS_COL columns at the same address) per cycle and absorbs downstream backpressure with an internal 2-entry skid FIFO, so no read is ever lost or repeated.

## Interface
- SYS_COL, 4, number of output-memory columns packed into one beat
- DATA_WIDTH, 32, bits per column word
- ADDR_WIDTH, 8, output-memory row address width
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin a drain; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first row address; latched with start
- num_row  in  16  rows to drain; latched with start
- mem_rd_en  out  SYS_COL  per-column read enable, all bits equal
- mem_rd_addr  out  ADDR_WIDTH x SYS_COL (unpacked [0:SYS_COL-1])  read address, all entries equal
- mem_rd_data  in  DATA_WIDTH x SYS_COL (unpacked [0:SYS_COL-1])  read data, valid the cycle after mem_rd_en
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  SYS_COL*DATA_WIDTH  column 0 in bits [DATA_WIDTH-1:0], column k at [k*DATA_WIDTH +: DATA_WIDTH]
- out_last  out  1  qualifies final beat of the drain
- busy  out  1  drain in progress
- done  out  1  one-cycle completion pulse
- checksum  out  DATA_WIDTH  present only with OUT_DRAIN_CHECKSUM_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches base_addr, num_row; clears issue/pop counters → RUN. If num_row=0 → DONE directly, no reads.
- RUN: issue read when issued < num_row and (fifo_occ + inflight − pop) < 2, where pop = out_valid & out_ready. Issue drives mem_rd_en all ones, mem_rd_addr = base_addr + issued (mod 2^ADDR_WIDTH, wraps silently). Returned data written into FIFO the next cycle; inflight is the 1-bit "read issued last cycle" flag.
- out_valid = FIFO non-empty; out_data = FIFO head; out_last = out_valid & (popped == num_row−1).
- After the pop with out_last → DONE. DONE lasts one cycle, asserts done, → IDLE.
- start while not IDLE ignored. out_data/out_last held stable while out_valid & ~out_ready.
- mem_rd_en/mem_rd_addr combinational from state and counters; mem_rd_addr = base when not reading.

## Timing
- Reset values: mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, checksum=0; state IDLE, FIFO empty.
- start in cycle 0 → first mem_rd_en in cycle 1 → data in cycle 2 → out_valid in cycle 3.
- out_ready held high: one beat per cycle; N rows take N+3 cycles from start to done pulse (done in cycle after last handshake).
- busy=1 from cycle 1 through DONE cycle inclusive; 0 in IDLE.
- out_ready low: at most 2 rows buffered; reads stall; no address skipped or repeated on release.
- Reset asserted mid-drain: immediate return to reset values; pending reads/FIFO contents discarded; no done.

## Configuration
- OUT_DRAIN_CHECKSUM_EN defined: checksum port exists; cleared on accepted start; on every handshake adds all SYS_COL words of the beat (modulo 2^DATA_WIDTH); holds final value after done until next start.
- Undefined: checksum port and adder logic absent; all other behaviour identical.

## Test plan
- Basic: memory rows 0..3 column k = 10*row+k, base=0, num_row=4, out_ready=1 → beats {0,1,2,3},{10,11,12,13},{20..23},{30..33} in cycles 3..6, out_last on cycle 6, done cycle 7.
- Backpressure: same data, out_ready toggles 1,0,0,1,… → identical beat sequence, ≤2 mem reads ahead of pops, out_data stable while stalled.
- Wrap: base=254, num_row=4 → mem_rd_addr 254,255,0,1.
- Zero length: num_row=0 → no mem_rd_en, no out_valid, done pulses cycle 1, busy high cycle 1 only.
- Reset mid-drain: rstn low after 2 beats of 8 → all outputs 0 same cycle; new start base=0, num_row=2 drains normally.
- Checksum (macro on): basic scenario → checksum = 6+46+86+126 = 264 after done.

Source files
------------

// File: rtl/out_mem_drain.sv
// out_mem_drain: streams num_row consecutive output-memory rows, starting at
// base_addr, onto a valid/ready beat interface. One full row (all SYS_COL
// columns) is read per cycle; a 2-entry skid FIFO absorbs the one-cycle read
// latency plus downstream backpressure so no read is lost or repeated.
//
// Optional feature: define OUT_DRAIN_CHECKSUM_EN to add the checksum port, a
// running modulo-2^DATA_WIDTH sum of every word handed off downstream.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            begin a drain (sampled only while idle)
//   base_addr        first row address, latched with start
//   num_row          number of rows, latched with start
//   mem_rd_en        per-column read enable (all bits equal)
//   mem_rd_addr      per-column read address (all entries equal)
//   mem_rd_data      per-column read data, valid the cycle after mem_rd_en
//   out_valid/ready  beat handshake
//   out_data         beat payload, column k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_last         final beat of the drain
//   busy             drain in progress (run and done states)
//   done             one-cycle completion pulse
//   checksum         sum of accepted words (OUT_DRAIN_CHECKSUM_EN only)
module out_mem_drain #(
  parameter int unsigned SYS_COL    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [15:0]                   num_row,
  output logic [SYS_COL-1:0]            mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr [0:SYS_COL-1],
  input  logic [DATA_WIDTH-1:0]         mem_rd_data [0:SYS_COL-1],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SYS_COL*DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
`ifdef OUT_DRAIN_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]         checksum
`endif
);

  localparam int unsigned BeatWidth = SYS_COL * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           num_q;
  logic [15:0]           issued_q;
  logic [15:0]           popped_q;
  logic                  inflight_q;

  logic [BeatWidth-1:0]  fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;

  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic [2:0]            ahead;
  logic [BeatWidth-1:0]  wr_data;

  assign accept    = (state_q == StIdle) && start;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (popped_q == (num_q - 16'd1));
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  // Rows buffered or in flight once this cycle's pop leaves; never exceeds
  // the FIFO depth, so every returning read has a slot.
  assign ahead = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == StRun) && (issued_q < num_q) && (ahead < 3'd2);

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < SYS_COL; k++) begin
      wr_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_rd_data[k];
    end
  end

  always_comb begin
    mem_rd_en = '0;
    for (int k = 0; k < SYS_COL; k++) begin
      mem_rd_en[k]   = issue;
      // Address wraps modulo 2^ADDR_WIDTH by truncation.
      mem_rd_addr[k] = issue ? (base_q + ADDR_WIDTH'(issued_q)) : base_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_row == 16'd0) ? StDone : StRun;
      end
      StRun: begin
        if (pop && out_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        base_q   <= base_addr;
        num_q    <= num_row;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 16'd1;
        if (pop)   popped_q <= popped_q + 16'd1;
      end
    end
  end

  // Skid FIFO: written the cycle after a read issues, when data returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= '0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= wr_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef OUT_DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < SYS_COL; k++) begin
      beat_sum = beat_sum + out_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + beat_sum;
    end
  end
`endif

endmodule

// File: tb/tb_out_mem_drain.sv
module tb_out_mem_drain;
  localparam int SYS_COL    = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          start;
  logic [ADDR_WIDTH-1:0]         base_addr;
  logic [15:0]                   num_row;
  logic [SYS_COL-1:0]            mem_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_rd_addr [0:SYS_COL-1];
  logic [DATA_WIDTH-1:0]         mem_rd_data [0:SYS_COL-1];
  logic                          out_valid;
  logic                          out_ready;
  logic [SYS_COL*DATA_WIDTH-1:0] out_data;
  logic                          out_last;
  logic                          busy;
  logic                          done;
`ifdef OUT_DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]         checksum;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_beat_q [$];
  bit           exp_last_q [$];
  logic [7:0]   exp_addr_q [$];

  logic [31:0]  mem [0:255][0:3];

  out_mem_drain #(
    .SYS_COL   (SYS_COL),
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .base_addr  (base_addr),
    .num_row    (num_row),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef OUT_DRAIN_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Registered-read memory model: data valid the cycle after the enable.
  always @(posedge clk) begin
    if (mem_rd_en[0]) begin
      for (int k = 0; k < SYS_COL; k++) mem_rd_data[k] <= mem[mem_rd_addr[k]][k];
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reads and beats are matched against the scoreboard queues.
  int         ahead = 0;
  bit         prev_stall = 0;
  logic [127:0] prev_data;
  bit         prev_last;

  always @(negedge clk) begin
    if (!rstn) begin
      ahead      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (mem_rd_en != '0) begin
        chk("rd_en_all", mem_rd_en, 4'hF);
        if (exp_addr_q.size() == 0) chk("rd_unexpected", 1'b1, 1'b0);
        else begin
          logic [7:0] ea;
          ea = exp_addr_q.pop_front();
          for (int k = 0; k < SYS_COL; k++) chk("rd_addr", mem_rd_addr[k], ea);
        end
        ahead++;
      end
      if (out_valid && out_ready) begin
        if (exp_beat_q.size() == 0) chk("beat_unexpected", 1'b1, 1'b0);
        else begin
          chk("beat_data", out_data, exp_beat_q.pop_front());
          chk("beat_last", out_last, exp_last_q.pop_front());
        end
        ahead--;
      end
      if (ahead > 2) chk("read_ahead", ahead, 2);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic start_drain(input logic [7:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    base_addr = b;
    num_row   = n;
    start     = 1'b1;
    for (int r = 0; r < n; r++) begin
      logic [7:0]   a;
      logic [127:0] beat;
      a = b + 8'(r);
      for (int k = 0; k < SYS_COL; k++) beat[k*32 +: 32] = mem[a][k];
      exp_addr_q.push_back(a);
      exp_beat_q.push_back(beat);
      exp_last_q.push_back(r == n - 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp);
    bit got = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
      @(posedge clk); #1;
      out_ready = bp ? pat[i % 4] : 1'b1;
    end
    chk("done_seen", got, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    for (int r = 0; r < 256; r++)
      for (int k = 0; k < 4; k++) mem[r][k] = 32'(10 * r + k);
    rstn = 1'b0; start = 1'b0; base_addr = '0; num_row = '0; out_ready = 1'b1;
    #12;
    chk("rst_rd_en", mem_rd_en, 4'h0);
    chk("rst_rd_addr", mem_rd_addr[0], 8'd0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 128'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
`ifdef OUT_DRAIN_CHECKSUM_EN
    chk("rst_checksum", checksum, 32'd0);
`endif
    @(negedge clk); #1 rstn = 1'b1;

    // Basic: cycle-exact timing of a 4-row drain.
    start_drain(8'd0, 16'd4);
    @(negedge clk);
    chk("c1_busy", busy, 1'b1);
    chk("c1_rd_en", mem_rd_en, 4'hF);
    chk("c1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("c2_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("c3_valid", out_valid, 1'b1);
    chk("c3_last", out_last, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("c6_valid", out_valid, 1'b1);
    chk("c6_last", out_last, 1'b1);
    @(negedge clk);
    chk("c7_done", done, 1'b1);
    chk("c7_busy", busy, 1'b1);
    chk("c7_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("c8_done", done, 1'b0);
    chk("c8_busy", busy, 1'b0);
`ifdef OUT_DRAIN_CHECKSUM_EN
    chk("checksum", checksum, 32'd264);
`endif

    // Backpressure: same rows, ready pattern 1,0,0,1.
    start_drain(8'd0, 16'd4);
    wait_done(60, 1'b1);

    // Address wrap.
    start_drain(8'd254, 16'd4);
    wait_done(30, 1'b0);

    // Zero length.
    start_drain(8'd7, 16'd0);
    @(negedge clk);
    chk("z1_done", done, 1'b1);
    chk("z1_busy", busy, 1'b1);
    chk("z1_rd_en", mem_rd_en, 4'h0);
    chk("z1_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("z2_done", done, 1'b0);
    chk("z2_busy", busy, 1'b0);

    // Reset after two beats of eight.
    start_drain(8'd0, 16'd8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_data", out_data, 128'd0);
    chk("mr_last", out_last, 1'b0);
    chk("mr_rd_en", mem_rd_en, 4'h0);
    chk("mr_rd_addr", mem_rd_addr[0], 8'd0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_done", done, 1'b0);
    exp_beat_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    chk("mr_done_held", done, 1'b0);
    #1 rstn = 1'b1;
    start_drain(8'd0, 16'd2);
    wait_done(30, 1'b0);

    chk("beats_left", exp_beat_q.size(), 0);
    chk("reads_left", exp_addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
